// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding and port ids.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_RDATA  = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way picker: single requester wins outright, ties go to
// port 0 in fixed mode or to the port that did not win last in round-robin.
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       winner,
  output logic       any
);

  // Resolve the winner; with no request the winner value is a don't-care (port 0).
  always_comb begin
    winner = PORT0;
    any    = |req;
    case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = fixed ? PORT0 : ~last;
      default: winner = PORT0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares a single-port synchronous SRAM between two req/gnt/rvalid requesters.
// One access at a time: latch winner in IDLE, strobe SRAM in STROBE, return
// read data in RDATA.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_clken,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_q
);

  state_e        state_q, state_d;
  logic          last_q;
  logic          winner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;

  logic          pickWinner;
  logic          pickAny;
  logic          fixedMode;
  logic          takeAccess;
  logic          strobePhase;
  logic          rdataPhase;

  assign fixedMode   = (FIXED_PRIO != 0);
  assign takeAccess  = (state_q == ST_IDLE) && pickAny;
  assign strobePhase = (state_q == ST_STROBE);
  assign rdataPhase  = (state_q == ST_RDATA);

  arb_rr2 u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .fixed  (fixedMode),
    .winner (pickWinner),
    .any    (pickAny)
  );

  // Next-state logic: a read needs the extra RDATA cycle, a write does not.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pickAny) state_d = ST_STROBE;
      ST_STROBE: state_d = we_q ? ST_IDLE : ST_RDATA;
      ST_RDATA:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Access registers latch the winner's request once, so a later drop of req
  // does not disturb the access already in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= PORT1;
      winner_q <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (takeAccess) begin
      last_q   <= pickWinner;
      winner_q <= pickWinner;
      we_q     <= (pickWinner == PORT1) ? m1_we    : m0_we;
      addr_q   <= (pickWinner == PORT1) ? m1_addr  : m0_addr;
      wdata_q  <= (pickWinner == PORT1) ? m1_wdata : m0_wdata;
    end
  end

  // Per-port read data hold registers, updated only by that port's reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (rdataPhase) begin
      if (winner_q == PORT0) m0_rdata_q <= sram_q;
      else                   m1_rdata_q <= sram_q;
    end
  end

  // Output decode: strobes only in their own state; rdata passes sram_q through
  // during RDATA so data is valid alongside rvalid, then the hold register keeps it.
  always_comb begin
    sram_clken = strobePhase;
    sram_we    = strobePhase && we_q;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    m0_gnt     = strobePhase && (winner_q == PORT0);
    m1_gnt     = strobePhase && (winner_q == PORT1);
    m0_rvalid  = rdataPhase && (winner_q == PORT0);
    m1_rvalid  = rdataPhase && (winner_q == PORT1);
    m0_rdata   = m0_rvalid ? sram_q : m0_rdata_q;
    m1_rdata   = m1_rvalid ? sram_q : m1_rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter: a round-robin instance with a
// behavioural 1024x8 SRAM, plus a fixed-priority instance for the tie rule.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic       m0Req, m0We, m1Req, m1We;
  logic [9:0] m0Addr, m1Addr;
  logic [7:0] m0Wdata, m1Wdata;
  logic       m0Gnt, m0Rvalid, m1Gnt, m1Rvalid;
  logic [7:0] m0Rdata, m1Rdata;
  logic       sramClken, sramWe;
  logic [9:0] sramAddr;
  logic [7:0] sramWdata;
  logic [7:0] sramQ = 8'h00;

  logic       bM0Req, bM1Req;
  logic       bM0Gnt, bM0Rvalid, bM1Gnt, bM1Rvalid;
  logic [7:0] bM0Rdata, bM1Rdata;
  logic       bClken, bWe;
  logic [9:0] bAddr;
  logic [7:0] bWdata;
  logic [7:0] bQ = 8'h00;

  logic [7:0] memA [1024];
  logic       written [1024];

  int checkCount = 0;
  int passCount  = 0;
  int gntSeen;
  int rvalidSeen;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  sram_arbiter #(.AW(10), .DW(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_gnt(m0Gnt), .m0_rvalid(m0Rvalid), .m0_rdata(m0Rdata),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
    .m1_gnt(m1Gnt), .m1_rvalid(m1Rvalid), .m1_rdata(m1Rdata),
    .sram_clken(sramClken), .sram_we(sramWe), .sram_addr(sramAddr),
    .sram_wdata(sramWdata), .sram_q(sramQ)
  );

  sram_arbiter #(.AW(10), .DW(8), .FIXED_PRIO(1)) dutFixed (
    .clk(clk), .rst(rst),
    .m0_req(bM0Req), .m0_we(1'b0), .m0_addr(10'h000), .m0_wdata(8'h00),
    .m0_gnt(bM0Gnt), .m0_rvalid(bM0Rvalid), .m0_rdata(bM0Rdata),
    .m1_req(bM1Req), .m1_we(1'b0), .m1_addr(10'h000), .m1_wdata(8'h00),
    .m1_gnt(bM1Gnt), .m1_rvalid(bM1Rvalid), .m1_rdata(bM1Rdata),
    .sram_clken(bClken), .sram_we(bWe), .sram_addr(bAddr),
    .sram_wdata(bWdata), .sram_q(bQ)
  );

  // Power-on contents for locations that have never been written.
  function automatic logic [7:0] initVal(input logic [9:0] a);
    case (a)
      10'h155: initVal = 8'hA5;
      10'h010: initVal = 8'h11;
      10'h020: initVal = 8'h22;
      default: initVal = 8'h00;
    endcase
  endfunction

  // Behavioural synchronous SRAM behind the round-robin instance.
  always @(posedge clk) begin
    if (sramClken) begin
      if (sramWe) begin
        memA[sramAddr]    <= sramWdata;
        written[sramAddr] <= 1'b1;
      end else begin
        sramQ <= (written[sramAddr] === 1'b1) ? memA[sramAddr] : initVal(sramAddr);
      end
    end
  end

  // Trivial read-only SRAM behind the fixed-priority instance.
  always @(posedge clk) begin
    if (bClken && !bWe) bQ <= 8'h5A;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [9:0] addr, input logic [7:0] wdata);
    if (port == 1'b0) begin
      m0Req = req; m0We = we; m0Addr = addr; m0Wdata = wdata;
    end else begin
      m1Req = req; m1We = we; m1Addr = addr; m1Wdata = wdata;
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    bM0Req = 1'b0;
    bM1Req = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_m0_gnt", int'(m0Gnt), 0);
    checkOutput("rst_m1_rvalid", int'(m1Rvalid), 0);
    checkOutput("rst_clken", int'(sramClken), 0);
    checkOutput("rst_we", int'(sramWe), 0);
    checkOutput("rst_addr", int'(sramAddr), 0);
    checkOutput("rst_wdata", int'(sramWdata), 0);
    checkOutput("rst_m0_rdata", int'(m0Rdata), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single read by port 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h155, 8'h00);
    @(negedge clk);
    checkOutput("rd_m0_gnt", int'(m0Gnt), 1);
    checkOutput("rd_clken", int'(sramClken), 1);
    checkOutput("rd_addr", int'(sramAddr), 'h155);
    checkOutput("rd_we", int'(sramWe), 0);
    checkOutput("rd_m1_gnt", int'(m1Gnt), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    @(negedge clk);
    checkOutput("rd_m0_rvalid", int'(m0Rvalid), 1);
    checkOutput("rd_m0_rdata", int'(m0Rdata), 'hA5);
    checkOutput("rd_m0_gnt_off", int'(m0Gnt), 0);
    checkOutput("rd_m1_rvalid", int'(m1Rvalid), 0);
    checkOutput("rd_m1_rdata", int'(m1Rdata), 0);
    @(negedge clk);
    checkOutput("rd_rvalid_off", int'(m0Rvalid), 0);
    checkOutput("rd_rdata_hold", int'(m0Rdata), 'hA5);
    checkOutput("rd_clken_off", int'(sramClken), 0);

    // Port 1 write then read-back at the top address.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'h3FF, 8'h3C);
    @(negedge clk);
    checkOutput("wr_m1_gnt", int'(m1Gnt), 1);
    checkOutput("wr_we", int'(sramWe), 1);
    checkOutput("wr_addr", int'(sramAddr), 'h3FF);
    checkOutput("wr_wdata", int'(sramWdata), 'h3C);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    @(negedge clk);
    checkOutput("wr_we_off", int'(sramWe), 0);
    checkOutput("wr_gnt_off", int'(m1Gnt), 0);
    checkOutput("wr_addr_hold", int'(sramAddr), 'h3FF);
    checkOutput("wr_wdata_hold", int'(sramWdata), 'h3C);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    @(negedge clk);
    checkOutput("rb_m1_gnt", int'(m1Gnt), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    @(negedge clk);
    checkOutput("rb_m1_rvalid", int'(m1Rvalid), 1);
    checkOutput("rb_m1_rdata", int'(m1Rdata), 'h3C);
    checkOutput("rb_m0_rdata_kept", int'(m0Rdata), 'hA5);
    @(negedge clk);

    // Round-robin contention straight out of reset.
    rst = 1'b0;
    #1;
    checkOutput("rst2_m0_rdata", int'(m0Rdata), 0);
    checkOutput("rst2_m1_rdata", int'(m1Rdata), 0);
    checkOutput("rst2_addr", int'(sramAddr), 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h010, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h020, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_m0_gnt_c%0d", c), int'(m0Gnt), int'(c == 1 || c == 7));
      checkOutput($sformatf("rr_m1_gnt_c%0d", c), int'(m1Gnt), int'(c == 4 || c == 10));
      checkOutput($sformatf("rr_m0_rvalid_c%0d", c), int'(m0Rvalid), int'(c == 2 || c == 8));
      checkOutput($sformatf("rr_m1_rvalid_c%0d", c), int'(m1Rvalid), int'(c == 5 || c == 11));
      if (c == 2) checkOutput("rr_m0_rdata", int'(m0Rdata), 'h11);
      if (c == 5) checkOutput("rr_m1_rdata", int'(m1Rdata), 'h22);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    @(negedge clk);

    // Reset asserted while a read is in STROBE.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h155, 8'h00);
    @(negedge clk);
    checkOutput("mid_gnt_before", int'(m0Gnt), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    rst = 1'b0;
    #1;
    checkOutput("mid_gnt_now", int'(m0Gnt), 0);
    checkOutput("mid_clken_now", int'(sramClken), 0);
    checkOutput("mid_addr_now", int'(sramAddr), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_no_rvalid1", int'(m0Rvalid), 0);
    @(negedge clk);
    checkOutput("mid_no_rvalid2", int'(m0Rvalid), 0);
    checkOutput("mid_no_clken", int'(sramClken), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    @(negedge clk);
    checkOutput("mid_next_gnt", int'(m1Gnt), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    @(negedge clk);
    checkOutput("mid_next_rvalid", int'(m1Rvalid), 1);
    checkOutput("mid_next_rdata", int'(m1Rdata), 'h3C);
    @(negedge clk);

    // Request dropped once latched: exactly one gnt and one rvalid.
    gntSeen    = 0;
    rvalidSeen = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h155, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0Gnt) begin
        gntSeen++;
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      end
      if (m0Rvalid) rvalidSeen++;
    end
    checkOutput("drop_gnt_count", gntSeen, 1);
    checkOutput("drop_rvalid_count", rvalidSeen, 1);
    checkOutput("drop_rdata", int'(m0Rdata), 'hA5);

    // Fixed priority: port 0 monopolises until it drops its request.
    bM0Req = 1'b1;
    bM1Req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("fx_m0_gnt_c%0d", c), int'(bM0Gnt), int'(c == 1 || c == 4 || c == 7));
      checkOutput($sformatf("fx_m1_gnt_c%0d", c), int'(bM1Gnt), int'(c == 10));
      if (c == 8) bM0Req = 1'b0;
    end
    bM1Req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
